// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver.
//   SIPO_WIDTH_DEF      default data word width
//   sipo_frame_len()    bits per frame: WIDTH, or WIDTH+1 when SIPO_PARITY_EN adds a parity bit
//   sipo_hs_t           registered handshake status {par_valid, overrun}
// Optional feature macro: SIPO_PARITY_EN (even-parity bit appended to every frame).
package sipo_pkg;

  localparam int unsigned SIPO_WIDTH_DEF = 4;

`ifdef SIPO_PARITY_EN
  localparam bit SIPO_PARITY = 1'b1;
`else
  localparam bit SIPO_PARITY = 1'b0;
`endif

  function automatic int unsigned sipo_frame_len(input int unsigned width);
    return SIPO_PARITY ? width + 1 : width;
  endfunction

  localparam int unsigned SIPO_FRAME_LEN_DEF = sipo_frame_len(SIPO_WIDTH_DEF);

  typedef struct packed {
    logic par_valid;
    logic overrun;
  } sipo_hs_t;

endpackage

// File: rtl/sipo_bit_cnt.sv
// Modulo-Mod bit counter for the deserializer frame.
//   clk_i  clock              rst_i  async reset, active-high
//   clr_i  synchronous clear (wins over inc_i)
//   inc_i  advance by one, wrapping Mod-1 -> 0
//   cnt_o  current count      tc_o   count is at Mod-1 (next increment completes a frame)
module sipo_bit_cnt #(
  parameter int unsigned Mod  = 4,
  parameter int unsigned CntW = $clog2(Mod + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tc_o  = (cnt_q == CntW'(Mod - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver, MSB first, with a valid/ready word output.
//   c          clock                   rst        async reset, active-high
//   clr        abort partial word      ser_in     serial data bit
//   ser_valid  sample ser_in this edge par_out    last completed word (MSB = first bit)
//   par_err    parity error flag (only with SIPO_PARITY_EN)
//   par_valid  par_out unconsumed      par_ready  consumer accepts when par_valid && par_ready
//   overrun    one-cycle pulse, completed word dropped
//   bit_cnt    bits collected for the current frame
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity bit and the par_err port.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             c,
  input  logic             rst,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] par_out,
`ifdef SIPO_PARITY_EN
  output logic             par_err,
`endif
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned FrameLen = sipo_frame_len(WIDTH);
  // Without parity the last data bit bypasses the register, so only WIDTH-1 bits are stored.
  localparam int unsigned SrW      = SIPO_PARITY ? WIDTH : WIDTH - 1;

  logic [SrW-1:0]   sr_d, sr_q;
  logic [WIDTH-1:0] par_out_d, par_out_q;
  logic [WIDTH-1:0] word_new;
  logic             err_new, par_err_d, par_err_q;
  sipo_hs_t         hs_d, hs_q;
  logic             take, done, tc;

  sipo_bit_cnt #(
    .Mod  (FrameLen),
    .CntW (CNT_W)
  ) u_bit_cnt (
    .clk_i (c),
    .rst_i (rst),
    .clr_i (clr),
    .inc_i (ser_valid),
    .cnt_o (bit_cnt),
    .tc_o  (tc)
  );

  assign take = ser_valid & ~clr;
  assign done = take & tc;

  always_comb begin
    if (SIPO_PARITY) begin
      word_new = WIDTH'(sr_q);
      err_new  = (^sr_q) ^ ser_in;
    end else begin
      word_new = WIDTH'({sr_q, ser_in});
      err_new  = 1'b0;
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (take && !(SIPO_PARITY && tc)) begin
      // The parity bit is not data; it is never shifted in.
      sr_d = SrW'({sr_q, ser_in});
    end
  end

  always_comb begin
    par_out_d      = par_out_q;
    par_err_d      = par_err_q;
    hs_d.par_valid = hs_q.par_valid;
    hs_d.overrun   = 1'b0;
    if (done) begin
      if (hs_q.par_valid && !par_ready) begin
        hs_d.overrun = 1'b1;
      end else begin
        par_out_d      = word_new;
        par_err_d      = err_new;
        hs_d.par_valid = 1'b1;
      end
    end else if (hs_q.par_valid && par_ready) begin
      hs_d.par_valid = 1'b0;
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      par_out_q <= '0;
      par_err_q <= 1'b0;
      hs_q      <= '0;
    end else begin
      sr_q      <= sr_d;
      par_out_q <= par_out_d;
      par_err_q <= par_err_d;
      hs_q      <= hs_d;
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = hs_q.par_valid;
  assign overrun   = hs_q.overrun;

`ifdef SIPO_PARITY_EN
  assign par_err = par_err_q;
`else
  logic unused_par_err;
  assign unused_par_err = par_err_q ^ err_new;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed sequences plus random traffic,
// compared against a frame-level reference model through a scoreboard queue.
module tb_sipo_deserializer;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic          c = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          ser_in = 1'b0;
  logic          ser_valid = 1'b0;
  logic          par_ready = 1'b0;
  logic [W-1:0]  par_out;
  logic          par_valid;
  logic          overrun;
  logic [CW-1:0] bit_cnt;
  logic          par_err_dut;

  sipo_deserializer #(
    .WIDTH (W)
  ) dut (
    .c         (c),
    .rst       (rst),
    .clr       (clr),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .par_out   (par_out),
`ifdef SIPO_PARITY_EN
    .par_err   (par_err_dut),
`endif
    .par_valid (par_valid),
    .par_ready (par_ready),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

`ifndef SIPO_PARITY_EN
  assign par_err_dut = 1'b0;
`endif

  always #5 c = ~c;

  typedef struct {
    logic [W-1:0] word;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  int           bits[$];
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         m_err = 1'b0;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_word  = '0;
    m_err   = 1'b0;
  endtask

  // Effect of one clock edge given the inputs that were held across it.
  task automatic model_step();
    bit   acc  = m_valid && par_ready;
    bit   done = 0;
    int   w    = 0;
    int   ones = 0;
    exp_t e;
    m_ovr = 1'b0;
    if (clr) begin
      bits.delete();
    end else if (ser_valid) begin
      bits.push_back(int'(ser_in));
      if (bits.size() == FRAME) begin
        done = 1;
        for (int i = 0; i < W; i++) w = w * 2 + bits[i];
        for (int i = 0; i < FRAME; i++) ones += bits[i];
        bits.delete();
        if (m_valid && !par_ready) begin
          m_ovr = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_word  = W'(w);
`ifdef SIPO_PARITY_EN
          m_err   = (ones % 2) != 0;
`else
          m_err   = 1'b0;
`endif
          e.word = m_word;
          e.err  = m_err;
          exp_q.push_back(e);
        end
      end
    end
    if (!done && acc) m_valid = 1'b0;
  endtask

  // Monitor: outputs sampled mid-cycle, away from the active edge.
  always @(negedge c) begin
    if (!rst) begin
      exp_t e;
      check("par_valid", 32'(par_valid), 32'(m_valid));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("bit_cnt", 32'(bit_cnt), 32'(bits.size()));
      if (m_valid) check("par_out_hold", 32'(par_out), 32'(m_word));
      if (par_valid && par_ready) begin
        check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_word", 32'(par_out), 32'(e.word));
          check("sb_par_err", 32'(par_err_dut), 32'(e.err));
        end
      end
    end
  end

  task automatic cyc(input logic sv, input logic b, input logic rdy, input logic cl);
    @(posedge c);
    #2;
    model_step();
    ser_valid = sv;
    ser_in    = b;
    par_ready = rdy;
    clr       = cl;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy, input int gap);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(1'b1, w[i], rdy, 1'b0);
      repeat (gap) cyc(1'b0, 1'b0, rdy, 1'b0);
    end
`ifdef SIPO_PARITY_EN
    cyc(1'b1, ^w, rdy, 1'b0);
`endif
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc(1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    @(posedge c);
    #2;
    model_step();
    ser_valid = 1'b0;
    clr       = 1'b0;
    par_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("arst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("arst_par_valid", 32'(par_valid), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_par_out", 32'(par_out), 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [W-1:0] w;
    #3;
    check("rst_par_out", 32'(par_out), 32'd0);
    check("rst_par_valid", 32'(par_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("rst_par_err", 32'(par_err_dut), 32'd0);
    repeat (2) @(posedge c);
    #2;
    rst = 1'b0;
    model_reset();

    // Basic word with consumer always ready.
    send_word(4'b0011, 1'b1, 0);
    idle(3, 1'b1);

    // Held word, then a second completion while not ready -> dropped with overrun.
    send_word(4'b1010, 1'b0, 0);
    send_word(4'b1111, 1'b0, 0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Abort a partial word with clr (bit on the clr edge is discarded).
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(4'b0101, 1'b1, 0);
    idle(2, 1'b1);

    // Gaps between bits.
    send_word(4'b1001, 1'b1, 3);
    idle(2, 1'b1);

    // Completion and accept on the same edge.
    send_word(4'b0011, 1'b0, 0);
    idle(1, 1'b0);
    w = 4'b1100;
    for (int i = W - 1; i >= 1; i--) cyc(1'b1, w[i], 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, w[0], 1'b0, 1'b0);
    cyc(1'b1, ^w, 1'b1, 1'b0);
`else
    cyc(1'b1, w[0], 1'b1, 1'b0);
`endif
    idle(3, 1'b1);

    // Asynchronous reset mid-word with a word pending.
    send_word(4'b0110, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    mid_reset();
    send_word(4'b0110, 1'b1, 0);
    idle(2, 1'b1);
`ifdef SIPO_PARITY_EN
    // Bad parity frame.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
`endif

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end
    end

    idle(2 * FRAME + 4, 1'b1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. Collects a serial bitstream one bit per qualified clock edge and presents completed WIDTH-bit words on a parallel port.
- Words are delivered through a valid/ready handshake.
- This is the receive end for the team's parallel-load shift/rotate serializers. Bits arrive MSB first, the order a left-shifting register emits them.

Parameters:
- WIDTH, 4, data word width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- c  input  1  clock; all state updates on posedge c.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous abort of the partial word in progress.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled on this edge.
- par_out  output  WIDTH  last completed word, MSB = first received bit.
- par_valid  output  1  par_out holds an unconsumed word.
- par_ready  input  1  consumer accepts par_out when par_valid && par_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- bit_cnt  output  CNT_W  bits collected for the current word (0..WIDTH-1).

Behaviour:
- Interface: one clock, c. Reset rst is asynchronous and active-high.
- Reset values: shift register = 0; bit_cnt = 0; par_out = 0; par_valid = 0; overrun = 0.
- Shift: on posedge c with ser_valid=1 and clr=0, sr <= {sr[WIDTH-2:0], ser_in} and bit_cnt increments.
- Word completion: occurs when ser_valid=1 and bit_cnt==WIDTH-1.
  - Completed word {sr[WIDTH-2:0], ser_in} goes to par_out.
  - par_valid <= 1 and bit_cnt <= 0.
  - Latency: par_valid is visible in the cycle after the edge that sampled the last bit.
- Handshake:
  - par_valid stays high and par_out stays stable until an edge with par_valid && par_ready. At that edge par_valid <= 0, unless a new word completes on the same edge.
  - Completion and accept on the same edge: the new word loads into par_out, par_valid stays 1, no overrun.
  - Completion while par_valid=1 and par_ready=0: the new word is dropped, par_out keeps the old word, overrun pulses high for exactly one cycle, and bit_cnt still wraps to 0.
- ser_valid=0: sr and bit_cnt hold. Gaps between bits of any length are legal.
- clr=1: sr <= 0 and bit_cnt <= 0. clr has priority over ser_valid on the same edge, so that bit is discarded. par_out and par_valid are unaffected, and the handshake still completes normally.
- rst mid-word or while par_valid=1: all state returns to reset values immediately, without waiting for a clock edge. A pending word is lost and no overrun is reported.
- par_ready while par_valid=0: no effect.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit. The bit counter runs 0..WIDTH.
  - Completion occurs on the parity bit.
  - An extra output par_err (1 bit) is registered alongside par_out. par_err = XOR of the data bits and the parity bit.
  - par_err has the same valid/hold/drop rules as par_out and resets to 0.
  - bit_cnt range becomes 0..WIDTH.
- Undefined: no parity bit and no par_err port. Behaviour is exactly as above.

Decomposition:
- Shared package sipo_pkg holds:
  - SIPO_WIDTH_DEF = 4.
  - The frame-length constant (WIDTH, or WIDTH+1 with parity).
  - A typedef for the handshake status {par_valid, overrun}.
- One natural sub-module: sipo_bit_cnt, a modulo-frame-length counter with increment, synchronous clear, async reset and a terminal-count output. The top level holds the shift register, output register and handshake.

Test Plan:
- Reset then ser_in bits 0,0,1,1 with ser_valid=1 and par_ready=1 -> cycle after the 4th bit, par_out=4'b0011 and par_valid=1 for one cycle, overrun=0.
- Send 1,0,1,0 with par_ready=0, then 1,1,1,1 -> par_out stays 4'b1010, par_valid stays 1, overrun pulses one cycle after the 8th bit.
- Send 1,1,0 then clr=1 with ser_valid=1, then 0,1,0,1 -> par_out=4'b0101 and bit_cnt=0 after clr.
- Bits 1,0,0,1 with ser_valid dropping for 3 cycles between each bit -> par_out=4'b1001, bit_cnt holds during gaps.
- With par_valid=1 (4'b0011) held, assert par_ready on the same edge as the last bit of 4'b1100 -> par_out=4'b1100, par_valid stays 1, no overrun.
- Assert rst asynchronously after 2 bits (mid-cycle) -> bit_cnt=0 and par_valid=0 immediately. The next 4 bits 0,1,1,0 yield 4'b0110. With SIPO_PARITY_EN, frame 0,1,1,0,1 -> par_err=1.
